eda_frame_scan_ctrl: RTL and testbench

//   Sequences one image frame through the M x N pixel RAM used by the regional-max engine.
//   - Load phase: accepts a raster-order pixel stream (valid/ready) and drives the RAM write port.
//   - Scan phase: sweeps the RAM centre address over every pixel in raster order.
//   - Presents each window slot to the downstream comparator through a valid/ready handshake.
//   - Sits between the host pixel source, the image RAM and the regional-max compare unit.

---
 rtl/eda_frame_scan_ctrl_if.sv | 41 ++++
 rtl/eda_frame_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_eda_frame_scan_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/eda_frame_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : eda_frame_scan_ctrl_if
// Purpose  : Bundles the frame-scan controller's host, RAM and comparator
//            signals into one interface.
//   master : controller side (drives pix_ready, RAM write/centre port,
//            window handshake outputs, busy, done)
//   slave  : environment side (drives start, pixel stream, win_ready)
// Revision : 1.0  initial release
// ============================================================================
interface eda_frame_scan_ctrl_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 8
);
  logic                   start;
  logic                   pix_valid;
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic                   pix_ready;
  logic                   ram_write_en;
  logic [ADDR_WIDTH-1:0]  ram_wr_addr;
  logic [PIXEL_WIDTH-1:0] ram_pixel_in;
  logic [ADDR_WIDTH-1:0]  ram_center_addr;
  logic                   win_valid;
  logic                   win_ready;
  logic                   win_last;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, pix_valid, pix_data, win_ready,
    output pix_ready, ram_write_en, ram_wr_addr, ram_pixel_in,
           ram_center_addr, win_valid, win_last, busy, done
  );

  modport slave (
    output start, pix_valid, pix_data, win_ready,
    input  pix_ready, ram_write_en, ram_wr_addr, ram_pixel_in,
           ram_center_addr, win_valid, win_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/eda_frame_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eda_frame_scan_ctrl
// Purpose  : Sequences one M x N frame through the pixel RAM: loads a
//            raster-order pixel stream, then sweeps the window centre over
//            every pixel, handing each window to the comparator.
// Ports    : clk   - single rising-edge clock
//            reset - synchronous active-high reset
//            bus   - eda_frame_scan_ctrl_if.master (start, pixel stream,
//                    RAM write/centre port, window handshake, busy, done)
// Revision : 1.0  initial release
// ============================================================================
module eda_frame_scan_ctrl #(
  parameter int M           = 16,
  parameter int N           = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter int I_WIDTH     = $clog2(M),
  parameter int J_WIDTH     = $clog2(N),
  parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  eda_frame_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Wrap points compare against the real last index so non-power-of-two
  // frame sizes wrap correctly.
  localparam logic [I_WIDTH-1:0] C_I_LAST = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0] C_J_LAST = J_WIDTH'(N - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [I_WIDTH-1:0]     r_li;
  logic [J_WIDTH-1:0]     r_lj;
  logic [I_WIDTH-1:0]     r_si;
  logic [J_WIDTH-1:0]     r_sj;
  logic                   r_write_en;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [PIXEL_WIDTH-1:0] r_pixel;

  logic w_pix_ready;
  logic w_win_valid;
  logic w_busy;
  logic w_done;
  logic w_pix_fire;
  logic w_win_fire;
  logic w_load_last;
  logic w_scan_last;

  assign w_load_last = (r_li == C_I_LAST) && (r_lj == C_J_LAST);
  assign w_scan_last = (r_si == C_I_LAST) && (r_sj == C_J_LAST);
  assign w_pix_fire  = w_pix_ready && bus.pix_valid;
  assign w_win_fire  = w_win_valid && bus.win_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pix_ready  = 1'b0;
    w_win_valid  = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_pix_ready = 1'b1;
        if (bus.pix_valid && w_load_last) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Last registered write is on the RAM port during this cycle.
        w_state_next = SCAN;
      end
      SCAN: begin
        w_win_valid = 1'b1;
        if (bus.win_ready && w_scan_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load/scan counters and registered RAM write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_li       <= '0;
      r_lj       <= '0;
      r_si       <= '0;
      r_sj       <= '0;
      r_write_en <= 1'b0;
      r_wr_addr  <= '0;
      r_pixel    <= '0;
    end else begin
      r_write_en <= w_pix_fire;
      if (w_pix_fire) begin
        r_wr_addr <= {r_li, r_lj};
        r_pixel   <= bus.pix_data;
      end

      if ((r_state == IDLE) && bus.start) begin
        r_li <= '0;
        r_lj <= '0;
      end else if (w_pix_fire) begin
        if (w_load_last) begin
          r_li <= '0;
          r_lj <= '0;
        end else if (r_lj == C_J_LAST) begin
          r_lj <= '0;
          r_li <= r_li + 1'b1;
        end else begin
          r_lj <= r_lj + 1'b1;
        end
      end

      // The final handshake leaves the centre on the last pixel so it
      // still shows {M-1,N-1} through DONE.
      if (r_state == FLUSH) begin
        r_si <= '0;
        r_sj <= '0;
      end else if (w_win_fire && !w_scan_last) begin
        if (r_sj == C_J_LAST) begin
          r_sj <= '0;
          r_si <= r_si + 1'b1;
        end else begin
          r_sj <= r_sj + 1'b1;
        end
      end
    end
  end

  assign bus.pix_ready       = w_pix_ready;
  assign bus.ram_write_en    = r_write_en;
  assign bus.ram_wr_addr     = r_wr_addr;
  assign bus.ram_pixel_in    = r_pixel;
  assign bus.ram_center_addr = {r_si, r_sj};
  assign bus.win_valid       = w_win_valid;
  assign bus.win_last        = w_win_valid && w_scan_last;
  assign bus.busy            = w_busy;
  assign bus.done            = w_done;

endmodule
`default_nettype wire

// File: tb/tb_eda_frame_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eda_frame_scan_ctrl
// Purpose  : Directed self-checking bench for eda_frame_scan_ctrl: a 16x16
//            instance for frame timing, bubbles, backpressure, reset abort
//            and ignored start; a 5x3 instance for non-power-of-two wrap.
// Revision : 1.0  initial release
// ============================================================================
module tb_eda_frame_scan_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  eda_frame_scan_ctrl_if #(.PIXEL_WIDTH(8), .ADDR_WIDTH(8)) bus  ();
  eda_frame_scan_ctrl_if #(.PIXEL_WIDTH(8), .ADDR_WIDTH(5)) sbus ();

  eda_frame_scan_ctrl #(.M(16), .N(16), .PIXEL_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  eda_frame_scan_ctrl #(.M(5), .N(3), .PIXEL_WIDTH(8)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int d0;

  // done is a DUT output only, so counting it on the falling edge is race-free.
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".pix_ready"},    bus.pix_ready,       0);
    check({tag, ".write_en"},     bus.ram_write_en,    0);
    check({tag, ".wr_addr"},      bus.ram_wr_addr,     0);
    check({tag, ".pixel_in"},     bus.ram_pixel_in,    0);
    check({tag, ".center"},       bus.ram_center_addr, 0);
    check({tag, ".win_valid"},    bus.win_valid,       0);
    check({tag, ".win_last"},     bus.win_last,        0);
    check({tag, ".busy"},         bus.busy,            0);
    check({tag, ".done"},         bus.done,            0);
  endtask

  // Entered and left on a falling edge.
  task automatic apply_reset(input int cycles, input string tag);
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.win_ready  = 1'b0;
    sbus.start     = 1'b0;
    sbus.pix_valid = 1'b0;
    sbus.pix_data  = '0;
    sbus.win_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    check_zero(tag);
    reset = 1'b0;
  endtask

  // Caller raises bus.start beforehand; the first edge here moves IDLE->LOAD.
  // abort_at >= 0 returns (inputs quiet) when that beat is about to be sent.
  task automatic load_frame(input bit bubbles, input logic [7:0] seed, input int abort_at);
    int         beat = 0;
    int         cyc  = 0;
    bit         prev = 1'b0;
    logic [7:0] expd;
    while (beat < 256) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("ld.write_en", bus.ram_write_en, prev);
      if (prev) begin
        expd = 8'(beat - 1) + seed;
        check("ld.wr_addr", bus.ram_wr_addr, beat - 1);
        check("ld.pixel_in", bus.ram_pixel_in, expd);
      end
      if (beat == abort_at) begin
        bus.pix_valid = 1'b0;
        return;
      end
      check("ld.pix_ready", bus.pix_ready, 1);
      bus.pix_valid = bubbles ? (cyc % 2 == 0) : 1'b1;
      bus.pix_data  = 8'(beat) + seed;
      prev          = bus.pix_valid;
      if (bus.pix_valid) beat++;
      cyc++;
    end
    // FLUSH cycle: final write on the port, no window yet.
    @(negedge clk);
    bus.pix_valid = 1'b0;
    expd = 8'd255 + seed;
    check("fl.write_en",  bus.ram_write_en, 1);
    check("fl.wr_addr",   bus.ram_wr_addr,  255);
    check("fl.pixel_in",  bus.ram_pixel_in, expd);
    check("fl.pix_ready", bus.pix_ready,    0);
    check("fl.win_valid", bus.win_valid,    0);
    check("fl.busy",      bus.busy,         1);
  endtask

  task automatic scan_frame(input int stall_at, input int stall_len, input int abort_at,
                            input int start_at);
    int k     = 0;
    int stall = 0;
    while (k < 256) begin
      @(negedge clk);
      check("sc.win_valid", bus.win_valid,       1);
      check("sc.center",    bus.ram_center_addr, k);
      check("sc.win_last",  bus.win_last,        (k == 255));
      check("sc.done",      bus.done,            0);
      check("sc.write_en",  bus.ram_write_en,    0);
      if (k == abort_at) begin
        bus.win_ready = 1'b0;
        return;
      end
      bus.start = (k == start_at);
      if (k == stall_at && stall < stall_len) begin
        bus.win_ready = 1'b0;
        stall++;
      end else begin
        bus.win_ready = 1'b1;
        k++;
      end
    end
    @(negedge clk);
    bus.win_ready = 1'b0;
    bus.start     = 1'b0;
    check("dn.done",      bus.done,            1);
    check("dn.win_valid", bus.win_valid,       0);
    check("dn.center",    bus.ram_center_addr, 255);
    check("dn.busy",      bus.busy,            1);
    @(negedge clk);
    check("id.done",      bus.done,            0);
    check("id.busy",      bus.busy,            0);
    check("id.pix_ready", bus.pix_ready,       0);
  endtask

  function automatic logic [31:0] s_addr(input int n);
    return 32'(((n / 3) << 2) | (n % 3));
  endfunction

  task automatic small_frame();
    int nw       = 0;
    int nwin     = 0;
    int b        = 0;
    bit seen_done = 1'b0;
    sbus.start     = 1'b1;
    sbus.win_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      @(negedge clk);
      sbus.start = 1'b0;
      if (sbus.ram_write_en) begin
        check("s.wr_addr", sbus.ram_wr_addr, s_addr(nw));
        nw++;
      end
      if (sbus.win_valid) begin
        check("s.center",   sbus.ram_center_addr, s_addr(nwin));
        check("s.win_last", sbus.win_last,        (nwin == 14));
        nwin++;
      end
      if (sbus.done) seen_done = 1'b1;
      sbus.pix_valid = (b < 15);
      sbus.pix_data  = 8'(b);
      if (sbus.pix_ready && sbus.pix_valid) b++;
    end
    sbus.pix_valid = 1'b0;
    check("s.write_count",  nw,        15);
    check("s.window_count", nwin,      15);
    check("s.done_seen",    seen_done, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0; bus.win_ready = 1'b0;
    sbus.start = 1'b0; sbus.pix_valid = 1'b0; sbus.pix_data = '0; sbus.win_ready = 1'b0;

    // Reset and a full back-to-back frame with pix_data = address.
    apply_reset(2, "rst");
    d0 = done_cnt;
    bus.start = 1'b1;
    load_frame(1'b0, 8'h00, -1);
    scan_frame(-1, 0, -1, -1);
    check("t1.done_count", done_cnt - d0, 1);

    // Input bubbles, then 5-cycle backpressure at centre 0x1F.
    bus.start = 1'b1;
    load_frame(1'b1, 8'h33, -1);
    scan_frame(31, 5, -1, -1);

    // Start pulsed mid-scan is ignored; exactly one done.
    d0 = done_cnt;
    bus.start = 1'b1;
    load_frame(1'b0, 8'h77, -1);
    scan_frame(-1, 0, -1, 100);
    repeat (3) begin
      @(negedge clk);
      check("t6.idle_busy", bus.busy, 0);
    end
    check("t6.done_count", done_cnt - d0, 1);

    // Reset during LOAD at beat 100 and during SCAN at centre 50.
    d0 = done_cnt;
    bus.start = 1'b1;
    load_frame(1'b0, 8'h00, 100);
    apply_reset(1, "rst_load");
    bus.start = 1'b1;
    load_frame(1'b0, 8'h00, -1);
    scan_frame(-1, 0, 50, -1);
    apply_reset(1, "rst_scan");
    repeat (2) @(negedge clk);
    check("t5.no_done", done_cnt - d0, 0);
    bus.start = 1'b1;
    load_frame(1'b0, 8'h11, -1);
    scan_frame(-1, 0, -1, -1);
    check("t5.done_count", done_cnt - d0, 1);

    // Non-power-of-two wrap on the 5x3 instance.
    small_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
